prim_fifo_wr_arb: RTL and testbench



---
 rtl/prim_fifo_wr_arb.sv | 204 ++++++++++++++++++++
 tb/tb_prim_fifo_wr_arb.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prim_fifo_wr_arb.sv
// Round-robin write-port arbiter for a shared prim_fifo_sync, with per-requester
// occupancy quota and source tagging. Optional error checking: PRIM_FIFO_WR_ARB_ERR_CHECK_EN.
module prim_fifo_wr_arb #(
  parameter int N         = 4,
  parameter int Width     = 16,
  parameter int MaxPerReq = 2,
  localparam int IdW      = (N > 1) ? $clog2(N) : 1,
  localparam int CntW     = ((MaxPerReq + 1) > 1) ? $clog2(MaxPerReq + 1) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic [N-1:0]        req_valid_i,
  output logic [N-1:0]        req_ready_o,
  input  logic [N*Width-1:0]  req_data_i,
  output logic                wvalid_o,
  input  logic                wready_i,
  output logic [Width-1:0]    wdata_o,
  output logic [IdW-1:0]      wid_o,
  input  logic                rel_valid_i,
  input  logic [IdW-1:0]      rel_id_i,
  output logic [N*CntW-1:0]   occ_o,
  output logic                err_o
);

  logic [CntW-1:0]  occ_r [N];
  logic [IdW-1:0]   rr_r;
  logic             lock_r;
  logic [IdW-1:0]   lock_idx_r;

  logic [N-1:0]     eligible_s;
  logic [Width-1:0] data_s [N];
  logic             found_s;
  logic [IdW-1:0]   pick_idx_s;
  logic             gnt_valid_s;
  logic [IdW-1:0]   gnt_idx_s;
  logic             hs_s;
  logic             stall_s;
  logic [IdW-1:0]   rr_next_s;
  logic [N-1:0]     inc_s;
  logic [N-1:0]     dec_s;
  int               scan_s;

  // Eligibility and per-requester data unpacking
  always_comb begin
    for (int i = 0; i < N; i++) begin
      eligible_s[i] = req_valid_i[i] & (occ_r[i] < CntW'(MaxPerReq));
      data_s[i]     = req_data_i[i*Width +: Width];
    end
  end

  // First eligible requester at or above the rr pointer, wrapping
  always_comb begin
    found_s    = 1'b0;
    pick_idx_s = {IdW{1'b0}};
    scan_s     = 0;
    for (int k = 0; k < N; k++) begin
      scan_s = int'(rr_r) + k;
      if (scan_s >= N) begin
        scan_s = scan_s - N;
      end else begin
        scan_s = scan_s;
      end
      if (!found_s && eligible_s[scan_s]) begin
        found_s    = 1'b1;
        pick_idx_s = IdW'(scan_s);
      end else begin
        found_s    = found_s;
      end
    end
  end

  // Grant selection; a stalled grant stays locked until it completes
  always_comb begin
    gnt_idx_s   = lock_r ? lock_idx_r : pick_idx_s;
    gnt_valid_s = (lock_r | found_s) & ~clr_i;
    hs_s        = gnt_valid_s & wready_i;
    stall_s     = gnt_valid_s & ~wready_i;
    if (gnt_idx_s == IdW'(N - 1)) begin
      rr_next_s = {IdW{1'b0}};
    end else begin
      rr_next_s = gnt_idx_s + IdW'(1);
    end
  end

  // Write-port and requester-ready outputs (zero-latency path)
  always_comb begin
    wvalid_o    = 1'b0;
    wid_o       = {IdW{1'b0}};
    wdata_o     = {Width{1'b0}};
    req_ready_o = {N{1'b0}};
    if (gnt_valid_s) begin
      wvalid_o               = 1'b1;
      wid_o                  = gnt_idx_s;
      wdata_o                = data_s[gnt_idx_s];
      req_ready_o[gnt_idx_s] = wready_i;
    end else begin
      wvalid_o               = 1'b0;
    end
  end

  // Per-requester increment/decrement requests; release is ignored during a flush
  always_comb begin
    for (int i = 0; i < N; i++) begin
      inc_s[i] = hs_s & (gnt_idx_s == IdW'(i));
      dec_s[i] = rel_valid_i & ~clr_i & (rel_id_i == IdW'(i)) & (occ_r[i] != {CntW{1'b0}});
    end
  end

  // Occupancy counters; a coincident handshake and release cancel out
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N; i++) begin
        occ_r[i] <= {CntW{1'b0}};
      end
    end else if (clr_i) begin
      for (int i = 0; i < N; i++) begin
        occ_r[i] <= {CntW{1'b0}};
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        case ({inc_s[i], dec_s[i]})
          2'b10:   occ_r[i] <= occ_r[i] + CntW'(1);
          2'b01:   occ_r[i] <= occ_r[i] - CntW'(1);
          default: occ_r[i] <= occ_r[i];
        endcase
      end
    end
  end

  // Round-robin pointer and stall lock
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_r       <= {IdW{1'b0}};
      lock_r     <= 1'b0;
      lock_idx_r <= {IdW{1'b0}};
    end else if (clr_i) begin
      rr_r       <= {IdW{1'b0}};
      lock_r     <= 1'b0;
      lock_idx_r <= {IdW{1'b0}};
    end else if (hs_s) begin
      rr_r       <= rr_next_s;
      lock_r     <= 1'b0;
      lock_idx_r <= lock_idx_r;
    end else if (stall_s) begin
      rr_r       <= rr_r;
      lock_r     <= 1'b1;
      lock_idx_r <= gnt_idx_s;
    end else begin
      rr_r       <= rr_r;
      lock_r     <= lock_r;
      lock_idx_r <= lock_idx_r;
    end
  end

  // Counters are registers, so the packed view is registered as well
  always_comb begin
    for (int i = 0; i < N; i++) begin
      occ_o[i*CntW +: CntW] = occ_r[i];
    end
  end

`ifdef PRIM_FIFO_WR_ARB_ERR_CHECK_EN
  logic err_r;
  logic err_set_s;

  // Protocol violations: release underflow, out-of-range id, locked requester dropping valid
  always_comb begin
    err_set_s = 1'b0;
    if (rel_valid_i && !clr_i) begin
      if (int'(rel_id_i) >= N) begin
        err_set_s = 1'b1;
      end else begin
        err_set_s = (occ_r[rel_id_i] == {CntW{1'b0}});
      end
    end else begin
      err_set_s = 1'b0;
    end
    if (lock_r && !req_valid_i[lock_idx_r]) begin
      err_set_s = 1'b1;
    end else begin
      err_set_s = err_set_s;
    end
  end

  // Sticky error flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_r <= 1'b0;
    end else if (clr_i) begin
      err_r <= 1'b0;
    end else if (err_set_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err_o = err_r;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_prim_fifo_wr_arb.sv
// Directed self-checking bench for prim_fifo_wr_arb (N=4, Width=16, MaxPerReq=2).
module tb_prim_fifo_wr_arb;

  localparam int N     = 4;
  localparam int Width = 16;
  localparam int IdW   = 2;
  localparam int CntW  = 2;

`ifdef PRIM_FIFO_WR_ARB_ERR_CHECK_EN
  localparam logic ExpErr = 1'b1;
`else
  localparam logic ExpErr = 1'b0;
`endif

  logic               clk_i;
  logic               rst_ni;
  logic               clr_i;
  logic [N-1:0]       req_valid_i;
  logic [N-1:0]       req_ready_o;
  logic [N*Width-1:0] req_data_i;
  logic               wvalid_o;
  logic               wready_i;
  logic [Width-1:0]   wdata_o;
  logic [IdW-1:0]     wid_o;
  logic               rel_valid_i;
  logic [IdW-1:0]     rel_id_i;
  logic [N*CntW-1:0]  occ_o;
  logic               err_o;

  int n_checks;
  int n_errors;

  logic [Width-1:0] dat [N];

  prim_fifo_wr_arb #(.N(N), .Width(Width), .MaxPerReq(2)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clr_i       (clr_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_data_i  (req_data_i),
    .wvalid_o    (wvalid_o),
    .wready_i    (wready_i),
    .wdata_o     (wdata_o),
    .wid_o       (wid_o),
    .rel_valid_i (rel_valid_i),
    .rel_id_i    (rel_id_i),
    .occ_o       (occ_o),
    .err_o       (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic flush();
    clr_i       = 1'b1;
    req_valid_i = 4'b0000;
    rel_valid_i = 1'b0;
    tick();
    clr_i       = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    dat[0] = 16'hA0A0;
    dat[1] = 16'hB1B1;
    dat[2] = 16'hC2C2;
    dat[3] = 16'hD3D3;
    req_data_i  = {dat[3], dat[2], dat[1], dat[0]};
    rst_ni      = 1'b0;
    clr_i       = 1'b0;
    req_valid_i = 4'b0000;
    wready_i    = 1'b0;
    rel_valid_i = 1'b0;
    rel_id_i    = 2'd0;

    #12;
    check("rst_wvalid", 32'(wvalid_o), 32'h0);
    check("rst_ready", 32'(req_ready_o), 32'h0);
    check("rst_wid", 32'(wid_o), 32'h0);
    check("rst_wdata", 32'(wdata_o), 32'h0);
    check("rst_occ", 32'(occ_o), 32'h0);
    check("rst_err", 32'(err_o), 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    // Contention: all four valid, always ready
    req_valid_i = 4'b1111;
    wready_i    = 1'b1;
    for (int k = 0; k < 8; k++) begin
      settle();
      check("cont_wvalid", 32'(wvalid_o), 32'h1);
      check("cont_wid", 32'(wid_o), 32'(k % 4));
      check("cont_wdata", 32'(wdata_o), 32'(dat[k % 4]));
      check("cont_ready", 32'(req_ready_o), 32'(4'b0001 << (k % 4)));
      tick();
    end
    check("cont_full_wvalid", 32'(wvalid_o), 32'h0);
    check("cont_full_occ", 32'(occ_o), 32'hAA);
    flush();
    check("cont_flush_occ", 32'(occ_o), 32'h0);

    // Back-pressure: requester 2 stalls, requester 0 joins
    req_valid_i = 4'b0100;
    wready_i    = 1'b0;
    settle();
    check("bp_wid0", 32'(wid_o), 32'h2);
    check("bp_ready0", 32'(req_ready_o), 32'h0);
    tick();
    req_valid_i = 4'b0101;
    for (int k = 0; k < 2; k++) begin
      settle();
      check("bp_wid", 32'(wid_o), 32'h2);
      check("bp_wdata", 32'(wdata_o), 32'hC2C2);
      check("bp_ready", 32'(req_ready_o), 32'h0);
      tick();
    end
    wready_i = 1'b1;
    settle();
    check("bp_hs_wid", 32'(wid_o), 32'h2);
    check("bp_hs_ready", 32'(req_ready_o), 32'h4);
    tick();
    settle();
    check("bp_next_wid", 32'(wid_o), 32'h0);
    check("bp_next_ready", 32'(req_ready_o), 32'h1);
    tick();
    req_valid_i = 4'b0000;
    check("bp_occ", 32'(occ_o), 32'h11);
    flush();

    // Quota: requester 1 alone
    req_valid_i = 4'b0010;
    wready_i    = 1'b1;
    for (int k = 0; k < 2; k++) begin
      settle();
      check("quota_wid", 32'(wid_o), 32'h1);
      tick();
    end
    settle();
    check("quota_block", 32'(wvalid_o), 32'h0);
    check("quota_occ2", 32'(occ_o), 32'h08);
    rel_valid_i = 1'b1;
    rel_id_i    = 2'd1;
    tick();
    rel_valid_i = 1'b0;
    settle();
    check("quota_occ1", 32'(occ_o), 32'h04);
    check("quota_wvalid", 32'(wvalid_o), 32'h1);
    check("quota_wid_after", 32'(wid_o), 32'h1);
    req_valid_i = 4'b0000;
    flush();

    // Simultaneous handshake and release
    req_valid_i = 4'b0001;
    settle();
    check("sim_wid0", 32'(wid_o), 32'h0);
    tick();
    req_valid_i = 4'b1000;
    settle();
    check("sim_wid3", 32'(wid_o), 32'h3);
    tick();
    check("sim_occ_pre", 32'(occ_o), 32'h41);
    rel_valid_i = 1'b1;
    rel_id_i    = 2'd3;
    settle();
    check("sim_wid3b", 32'(wid_o), 32'h3);
    tick();
    check("sim_occ_same", 32'(occ_o), 32'h41);
    rel_id_i = 2'd0;
    tick();
    rel_valid_i = 1'b0;
    req_valid_i = 4'b0000;
    check("sim_occ_diff", 32'(occ_o), 32'h80);
    flush();

    // Flush while stalled on requester 3
    req_valid_i = 4'b1011;
    wready_i    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
    end
    req_valid_i = 4'b1000;
    wready_i    = 1'b0;
    check("fl_occ_pre", 32'(occ_o), 32'h46);
    tick();
    req_valid_i = 4'b1011;
    settle();
    check("fl_locked_wid", 32'(wid_o), 32'h3);
    clr_i       = 1'b1;
    wready_i    = 1'b1;
    rel_valid_i = 1'b1;
    rel_id_i    = 2'd0;
    settle();
    check("fl_clr_wvalid", 32'(wvalid_o), 32'h0);
    check("fl_clr_ready", 32'(req_ready_o), 32'h0);
    tick();
    clr_i       = 1'b0;
    rel_valid_i = 1'b0;
    settle();
    check("fl_occ", 32'(occ_o), 32'h0);
    check("fl_wid_restart", 32'(wid_o), 32'h0);
    check("fl_err", 32'(err_o), 32'h0);
    req_valid_i = 4'b0000;
    wready_i    = 1'b0;
    flush();

    // Release underflow
    rel_valid_i = 1'b1;
    rel_id_i    = 2'd2;
    tick();
    rel_valid_i = 1'b0;
    check("err_set", 32'(err_o), 32'(ExpErr));
    check("err_occ", 32'(occ_o), 32'h0);
    tick();
    tick();
    check("err_sticky", 32'(err_o), 32'(ExpErr));
    flush();
    check("err_clr", 32'(err_o), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
